// File: rtl/arm_one_nios_pll_sup_pkg.sv
// Shared state encoding and constants for the PLL lock supervisor.
package arm_one_nios_pll_sup_pkg;

  localparam int unsigned RETRY_CNT_W = 8;

  typedef enum logic [2:0] {
    StPulse,
    StWaitLock,
    StStable,
    StRun,
    StFault
  } sup_state_e;

endpackage

// File: rtl/arm_one_nios_sync2.sv
// Two-flop synchronizer for a single asynchronous level, synchronous active-high clear.
module arm_one_nios_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/arm_one_nios_pll_supervisor.sv
// PLL lock supervisor / reset sequencer on refclk. Define PLL_SUP_FAULT_EN to enable the
// sticky FAULT state after MAX_RETRIES consecutive failed lock attempts.
module arm_one_nios_pll_supervisor
  import arm_one_nios_pll_sup_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   locked,
  output logic                   pll_rst,
  output logic                   sys_rst,
  output logic                   lock_ok,
  output logic [RETRY_CNT_W-1:0] retry_cnt,
  output logic                   fault
);

  localparam int unsigned TimerMax = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam int unsigned StableW  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned FailW    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [TimerW-1:0]  PulseLast   = TimerW'(RST_PULSE_CYCLES - 1);
  localparam logic [TimerW-1:0]  TimeoutLast = TimerW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [StableW-1:0] StableLast  = StableW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [FailW-1:0]   FailMax     = FailW'(MAX_RETRIES);
`ifdef PLL_SUP_FAULT_EN
  localparam logic [FailW-1:0]   FailLast    = FailW'(MAX_RETRIES - 1);
`endif

  sup_state_e             state_q, state_d;
  logic [TimerW-1:0]      timer_q, timer_d;
  logic [StableW-1:0]     stable_q, stable_d;
  logic [FailW-1:0]       fail_q, fail_d;
  logic [RETRY_CNT_W-1:0] retry_q, retry_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   lock_ok_q, lock_ok_d;
  logic                   fail_event;
  logic                   locked_s;
  logic                   sync_clr;

  // Lock is meaningless while the PLL is held in reset; keep the synchronizer cleared so a
  // stale lock from before the pulse cannot leak into WAIT_LOCK.
  assign sync_clr = rst | pll_rst_q;

  arm_one_nios_sync2 u_lock_sync (
    .clk_i (refclk),
    .rst_i (sync_clr),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    stable_d   = stable_q;
    fail_d     = fail_q;
    retry_d    = retry_q;
    fail_event = 1'b0;

    unique case (state_q)
      StPulse: begin
        if (timer_q == PulseLast) begin
          state_d = StWaitLock;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWaitLock: begin
        if (locked_s) begin
          state_d  = StStable;
          stable_d = '0;
        end else if (timer_q == TimeoutLast) begin
          fail_event = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StStable: begin
        if (!locked_s) begin
          state_d = StWaitLock;
          timer_d = '0;
        end else if (stable_q == StableLast) begin
          state_d = StRun;
          fail_d  = '0;
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end
      StRun: begin
        if (!locked_s) fail_event = 1'b1;
      end
`ifdef PLL_SUP_FAULT_EN
      StFault: begin
        state_d = StFault;
      end
`endif
      default: begin
        state_d = StPulse;
        timer_d = '0;
      end
    endcase

    if (fail_event) begin
      state_d = StPulse;
      timer_d = '0;
      if (retry_q != '1)    retry_d = retry_q + 1'b1;
      if (fail_q != FailMax) fail_d = fail_q + 1'b1;
`ifdef PLL_SUP_FAULT_EN
      if (fail_q == FailLast) state_d = StFault;
`endif
    end
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_comb begin
    pll_rst_d = (state_d == StPulse) || (state_d == StFault);
    sys_rst_d = (state_d != StRun);
    lock_ok_d = (state_d == StRun);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= StPulse;
      timer_q   <= '0;
      stable_q  <= '0;
      fail_q    <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      lock_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      stable_q  <= stable_d;
      fail_q    <= fail_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      lock_ok_q <= lock_ok_d;
    end
  end

`ifdef PLL_SUP_FAULT_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = (state_d == StFault);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign lock_ok   = lock_ok_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_arm_one_nios_pll_supervisor.sv
// Directed bench for the PLL lock supervisor with small timing parameters (4/20/8/2).
module tb_arm_one_nios_pll_supervisor;

  logic       refclk = 1'b0;
  logic       rst    = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       lock_ok;
  logic [7:0] retry_cnt;
  logic       fault;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  arm_one_nios_pll_supervisor #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .locked    (locked),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .lock_ok   (lock_ok),
    .retry_cnt (retry_cnt),
    .fault     (fault)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    // Reset values, locked already high.
    rst    = 1'b1;
    locked = 1'b1;
    tick();
    tick();
    check_eq("rst_pll_rst", 32'(pll_rst), 1);
    check_eq("rst_sys_rst", 32'(sys_rst), 1);
    check_eq("rst_lock_ok", 32'(lock_ok), 0);
    check_eq("rst_retry", 32'(retry_cnt), 0);
    check_eq("rst_fault", 32'(fault), 0);

    // Clean start: 4-cycle pulse, sys_rst falls on edge 15.
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_eq("clean_pll_rst", 32'(pll_rst), 32'(k < 4));
      check_eq("clean_sys_rst", 32'(sys_rst), 32'(k < 15));
    end
    check_eq("clean_lock_ok", 32'(lock_ok), 1);
    check_eq("clean_retry", 32'(retry_cnt), 0);
    check_eq("clean_fault", 32'(fault), 0);

    // Lock loss in RUN: reset reasserted on the third edge, then a fresh sequence.
    locked = 1'b0;
    tick();
    tick();
    check_eq("loss_sys_rst_e2", 32'(sys_rst), 0);
    tick();
    check_eq("loss_sys_rst_e3", 32'(sys_rst), 1);
    check_eq("loss_pll_rst_e3", 32'(pll_rst), 1);
    check_eq("loss_lock_ok_e3", 32'(lock_ok), 0);
    check_eq("loss_retry", 32'(retry_cnt), 1);
    locked = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check_eq("loss_pll_rst", 32'(pll_rst), 32'(k < 4));
      check_eq("loss_sys_rst", 32'(sys_rst), 32'(k < 15));
    end
    check_eq("loss_retry_end", 32'(retry_cnt), 1);

    // Second loss, then rst while in STABLE.
    locked = 1'b0;
    tick();
    tick();
    tick();
    check_eq("loss2_retry", 32'(retry_cnt), 2);
    locked = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    check_eq("midstable_sys_rst", 32'(sys_rst), 1);
    check_eq("midstable_pll_rst", 32'(pll_rst), 0);
    rst = 1'b1;
    tick();
    check_eq("midrst_pll_rst", 32'(pll_rst), 1);
    check_eq("midrst_sys_rst", 32'(sys_rst), 1);
    check_eq("midrst_retry", 32'(retry_cnt), 0);
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check_eq("restart_pll_rst", 32'(pll_rst), 32'(k < 4));
      check_eq("restart_sys_rst", 32'(sys_rst), 32'(k < 15));
    end

    // Two-cycle dropout during STABLE restarts debounce; release moves to edge 22.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 9)  locked = 1'b0;
      if (k == 11) locked = 1'b1;
      check_eq("dropout_sys_rst", 32'(sys_rst), 32'(k < 22));
    end
    check_eq("dropout_retry", 32'(retry_cnt), 0);
    check_eq("dropout_lock_ok", 32'(lock_ok), 1);

    // Lock never arrives: pulse every 24 cycles (or FAULT after the second timeout).
    rst    = 1'b1;
    locked = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 75; k++) begin
      tick();
`ifdef PLL_SUP_FAULT_EN
      check_eq("nolock_pll_rst", 32'(pll_rst), (k >= 48) ? 1 : 32'((k % 24) < 4));
      check_eq("nolock_retry", 32'(retry_cnt), (k >= 48) ? 2 : (k / 24));
      check_eq("nolock_fault", 32'(fault), 32'(k >= 48));
`else
      check_eq("nolock_pll_rst", 32'(pll_rst), 32'((k % 24) < 4));
      check_eq("nolock_retry", 32'(retry_cnt), k / 24);
      check_eq("nolock_fault", 32'(fault), 0);
`endif
      check_eq("nolock_sys_rst", 32'(sys_rst), 1);
    end
    rst = 1'b1;
    tick();
    check_eq("clr_fault", 32'(fault), 0);
    check_eq("clr_retry", 32'(retry_cnt), 0);
    rst = 1'b0;

`ifndef PLL_SUP_FAULT_EN
    // retry_cnt saturates at 255.
    for (int k = 1; k <= 24 * 257; k++) begin
      tick();
      if (k == 24 * 254) check_eq("sat_254", 32'(retry_cnt), 254);
      if (k == 24 * 255) check_eq("sat_255", 32'(retry_cnt), 255);
      if (k == 24 * 257) check_eq("sat_hold", 32'(retry_cnt), 255);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
